// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 2^INDEX_BITS lines of 128 bits.
// Hits are served combinationally; a miss fetches the whole block from memory.
module instruction_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t state_q, state_d;

    logic [127:0]          data_array [LINES];
    logic [TAG_BITS-1:0]   tag_array  [LINES];
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [INDEX_BITS-1:0] fill_index;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [127:0]          line;
    logic                  hit;
    logic                  unused_byte_bits;

    assign offset           = address[3:2];
    assign index            = address[4 +: INDEX_BITS];
    assign tag              = address[31 -: TAG_BITS];
    assign unused_byte_bits = ^address[1:0];

    assign line        = data_array[index];
    assign instruction = line[{offset, 5'b0} +: 32];

    // Reset forces every lookup to miss, even before the valid bits clear.
    assign hit = !reset && valid[index] && (tag_array[index] == tag);

    assign mem_address = {fill_tag, fill_index};

    always_comb begin
        state_d  = state_q;
        busywait = 1'b0;
        mem_read = 1'b0;
        case (state_q)
            IDLE: begin
                busywait = read && !hit;
                if (read && !hit)
                    state_d = MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!mem_busywait)
                    state_d = UPDATE;
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            busywait = read;
            mem_read = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            valid      <= '0;
            fill_tag   <= '0;
            fill_index <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && read && !hit) begin
                fill_tag   <= tag;
                fill_index <= index;
            end
            if (state_q == UPDATE)
                valid[fill_index] <= 1'b1;
        end
    end

    // Block is captured one edge after memory reports done, when its last byte has landed.
    always_ff @(posedge clock) begin
        if (!reset && state_q == UPDATE) begin
            data_array[fill_index] <= mem_readdata;
            tag_array[fill_index]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus a randomized
// fetch stream checked against a transaction-level cache/memory model.
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 16;
    int mem_cnt = 0;

    // Reference model state: which block each line should hold.
    logic        ref_valid [8];
    logic [24:0] ref_tag   [8];

    instruction_cache #(.INDEX_BITS(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] blk;
        if (b == 28'h0)
            return 128'h001001b3_03210113_00208093_3e800013;
        for (int k = 0; k < 4; k++)
            blk[32*k +: 32] = ({b, 4'(k)} * 32'h9E3779B1) ^ 32'h5A5A0000;
        return blk;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [127:0] blk;
        blk = mem_block(a[31:4]);
        return blk[32*a[3:2] +: 32];
    endfunction

    // Memory: busy for mem_lat cycles of mem_read, not-busy on the last one.
    always @(posedge clock) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
    assign mem_busywait = (mem_cnt < mem_lat - 1);
    assign mem_readdata = mem_block(mem_address);

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        read  = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic run_fetch(input logic [31:0] a, output int busy, output int mr,
                             output bit addr_bad);
        @(posedge clock); #1;
        read    = 1'b1;
        address = a;
        busy = 0; mr = 0; addr_bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busywait) break;
            busy++;
            if (mem_read) begin
                mr++;
                if (mem_address !== a[31:4]) addr_bad = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; address = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (busywait !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busywait); end
        n_cmp++;
        if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_memread: got %b want 0", mem_read); end
        read = 1'b1;
        #1;
        n_cmp++;
        if (busywait !== 1'b1) begin n_bad++; $display("FAIL reset_busy_read: got %b want 1", busywait); end
        n_cmp++;
        if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_memread_read: got %b want 0", mem_read); end
        read = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_idle_quiet();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_cmp++;
            if (busywait !== 1'b0 || mem_read !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_quiet cycle %0d: busywait=%b mem_read=%b want 0/0", i, busywait, mem_read);
            end
        end
    endtask

    task automatic test_cold_miss();
        int busy, mr; bit bad;
        do_reset();
        mem_lat = 16;
        run_fetch(32'h4, busy, mr, bad);
        n_cmp++;
        if (busy != 18) begin n_bad++; $display("FAIL cold_busy_cycles: got %0d want 18", busy); end
        n_cmp++;
        if (mr != 16) begin n_bad++; $display("FAIL cold_memread_cycles: got %0d want 16", mr); end
        n_cmp++;
        if (bad) begin n_bad++; $display("FAIL cold_mem_address: got wrong address want 0000000"); end
        n_cmp++;
        if (instruction !== 32'h00208093) begin n_bad++; $display("FAIL cold_instr: got %h want 00208093", instruction); end
    endtask

    task automatic test_same_line_hit();
        int busy, mr; bit bad;
        run_fetch(32'hC, busy, mr, bad);
        n_cmp++;
        if (busy != 0) begin n_bad++; $display("FAIL hit_busy: got %0d cycles want 0", busy); end
        n_cmp++;
        if (instruction !== 32'h001001b3) begin n_bad++; $display("FAIL hit_instr: got %h want 001001b3", instruction); end
        n_cmp++;
        if (mem_read !== 1'b0) begin n_bad++; $display("FAIL hit_memread: got %b want 0", mem_read); end
    endtask

    task automatic test_conflict_miss();
        int busy, mr; bit bad;
        mem_lat = 3;
        run_fetch(32'h80, busy, mr, bad);
        n_cmp++;
        if (busy != 5 || mr != 3 || bad) begin
            n_bad++;
            $display("FAIL conflict_fill: busy=%0d mr=%0d addr_bad=%0d want 5/3/0", busy, mr, bad);
        end
        n_cmp++;
        if (instruction !== exp_word(32'h80)) begin
            n_bad++; $display("FAIL conflict_instr: got %h want %h", instruction, exp_word(32'h80));
        end
        run_fetch(32'h0, busy, mr, bad);
        n_cmp++;
        if (busy != 5 || bad) begin n_bad++; $display("FAIL conflict_remiss: busy=%0d want 5", busy); end
        n_cmp++;
        if (instruction !== 32'h3e800013) begin n_bad++; $display("FAIL conflict_reinstr: got %h want 3e800013", instruction); end
    endtask

    task automatic test_addr_change();
        int mr; int busy; bit bad; bit seen;
        mem_lat = 6;
        @(posedge clock); #1;
        read = 1'b1; address = 32'h10;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (mem_read !== 1'b1) begin n_bad++; $display("FAIL chg_in_fill: mem_read got %b want 1", mem_read); end
        @(posedge clock); #1;
        address = 32'h20;
        mr = 2; bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!mem_read) break;
            mr++;
            if (mem_address !== 28'h1) bad = 1'b1;
        end
        n_cmp++;
        if (mr != 6 || bad) begin n_bad++; $display("FAIL chg_first_fill: mr=%0d addr_bad=%0d want 6/0", mr, bad); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_read) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen || mem_address !== 28'h2) begin
            n_bad++; $display("FAIL chg_second_fill: started=%0d mem_address=%h want 1/0000002", seen, mem_address);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!busywait) break;
        end
        n_cmp++;
        if (instruction !== exp_word(32'h20)) begin
            n_bad++; $display("FAIL chg_instr20: got %h want %h", instruction, exp_word(32'h20));
        end
        run_fetch(32'h10, busy, mr, bad);
        n_cmp++;
        if (busy != 0 || instruction !== exp_word(32'h10)) begin
            n_bad++; $display("FAIL chg_line1_hit: busy=%0d instr=%h want 0/%h", busy, instruction, exp_word(32'h10));
        end
    endtask

    task automatic test_reset_mid_fill();
        int busy, mr; bit bad;
        mem_lat = 10;
        @(posedge clock); #1;
        read = 1'b1; address = 32'h40;
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1; read = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_read !== 1'b0 || busywait !== 1'b0) begin
            n_bad++; $display("FAIL rst_fill_during: mem_read=%b busywait=%b want 0/0", mem_read, busywait);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_fill_after: mem_read got %b want 0", mem_read); end
        run_fetch(32'h40, busy, mr, bad);
        n_cmp++;
        if (busy != 12 || mr != 10 || bad) begin
            n_bad++; $display("FAIL rst_fill_remiss: busy=%0d mr=%0d want 12/10", busy, mr);
        end
        run_fetch(32'h10, busy, mr, bad);
        n_cmp++;
        if (busy != 12) begin n_bad++; $display("FAIL rst_clears_valid: busy=%0d want 12", busy); end
    endtask

    task automatic test_random();
        int busy, mr; bit bad;
        logic [31:0] a;
        logic [2:0] idx;
        bit exp_hit;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            mem_lat   = $urandom_range(1, 4);
            a         = $urandom;
            a[31:7]   = 25'($urandom_range(0, 2));
            idx       = a[6:4];
            exp_hit   = ref_valid[idx] && (ref_tag[idx] == a[31:7]);
            run_fetch(a, busy, mr, bad);
            n_cmp++;
            if (busy != (exp_hit ? 0 : mem_lat + 2) || mr != (exp_hit ? 0 : mem_lat) || bad) begin
                n_bad++;
                $display("FAIL rand_timing %0d addr=%h: busy=%0d mr=%0d addr_bad=%0d want busy=%0d mr=%0d",
                         n, a, busy, mr, bad, exp_hit ? 0 : mem_lat + 2, exp_hit ? 0 : mem_lat);
            end
            n_cmp++;
            if (instruction !== exp_word(a)) begin
                n_bad++; $display("FAIL rand_instr %0d addr=%h: got %h want %h", n, a, instruction, exp_word(a));
            end
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[31:7];
        end
    endtask

    initial begin
        test_reset();
        test_idle_quiet();
        test_cold_miss();
        test_same_line_hit();
        test_conflict_miss();
        test_addr_change();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter: INDEX_BITS, default 3, log2 of line count (8 lines of 128 bits each).
REQ-002 Port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: read  in  1  CPU instruction-fetch request.
REQ-005 Port: address  in  32  CPU byte address of the fetch.
REQ-006 Port: instruction  out  32  fetched instruction word.
REQ-007 Port: busywait  out  1  CPU stall; high while the fetch is not yet served.
REQ-008 Port: mem_read  out  1  block read request to instruction memory.
REQ-009 Port: mem_address  out  28  block address to memory, equal to byte address [31:4].
REQ-010 Port: mem_readdata  in  128  block from memory; byte k of the block is bits [8k+7:8k].
REQ-011 Port: mem_busywait  in  1  memory busy; low means the block transfer completes at the next edge.

Function
REQ-012 Address split: word offset = address[3:2]; index = address[4+INDEX_BITS-1:4]; tag = address[31:4+INDEX_BITS]; address[1:0] are ignored.
REQ-013 Storage per line: valid bit, tag, 128-bit data; direct-mapped; no write path from the CPU.
REQ-014 instruction is combinational: data[32*offset+31:32*offset] of the line selected by the current index.
REQ-015 hit = valid[index] AND stored tag == tag, evaluated combinationally.
REQ-016 FSM states: IDLE, MEM_READ, UPDATE.
REQ-017 IDLE: busywait = read AND NOT hit; mem_read = 0.
REQ-018 IDLE with read AND hit: instruction is valid in the same cycle (zero-cycle hit latency); the state stays IDLE.
REQ-019 IDLE with read AND NOT hit: at the next edge, latch tag and index and go to MEM_READ.
REQ-020 MEM_READ: mem_read = 1; mem_address = {latched tag, latched index}; busywait = 1.
REQ-021 MEM_READ: stay while mem_busywait = 1; at the edge where mem_busywait = 0, go to UPDATE.
REQ-022 UPDATE: mem_read = 0; busywait = 1.
REQ-023 UPDATE: at the next edge, write mem_readdata into the latched line, set its tag, set valid = 1, and go to IDLE.
REQ-024 UPDATE exists because memory writes its last byte on the same edge it reports not-busy; capturing earlier is forbidden.
REQ-025 On return to IDLE, hit is re-evaluated against the current address; a held address hits with busywait = 0 in that cycle.
REQ-026 An address change by the CPU during MEM_READ or UPDATE does not alter the fill in progress.
REQ-027 read deasserted during MEM_READ does not abort the fill; the line is still filled.
REQ-028 A miss on a valid line replaces it unconditionally; no write-back is performed.
REQ-029 mem_address outside MEM_READ is don't-care but must not glitch mem_read.
REQ-030 Miss penalty with a memory busy for N cycles: busywait is high for 1 (detect) + N + 1 (UPDATE) cycles, then the hit cycle follows.

Reset
REQ-031 With reset high at an edge: state goes to IDLE, all valid bits clear, latched tag and index clear; data arrays are not cleared.
REQ-032 During and after reset: mem_read = 0; busywait = read (every lookup misses).
REQ-033 Reset asserted in MEM_READ or UPDATE aborts the fill; no line becomes valid.
REQ-034 Reset has priority over every other transition.

Verification
REQ-035 Cold miss: reset, then read = 1, address = 0x00000004, memory block 0 = {0x001001b3, 0x03210113, 0x00208093, 0x3e800013}, memory busy for 16 cycles -> mem_read high for exactly 16 cycles with mem_address = 0x0000000; busywait drops 18 cycles after the request; instruction = 0x00208093.
REQ-036 Same-line hit: after the cold-miss scenario, address = 0x0000000C -> busywait = 0 in the same cycle; instruction = 0x001001b3; mem_read stays 0.
REQ-037 Conflict miss: address = 0x00000080 (same index 0, tag 1) -> a new fill occurs with mem_address = 0x0000008; a subsequent read of 0x00000000 misses again.
REQ-038 Address change mid-fill: miss on 0x00000010, then the address switches to 0x00000020 during MEM_READ -> line 1 is filled with tag 0; on return to IDLE, 0x20 misses and starts a new fill.
REQ-039 Reset mid-fill: reset is pulsed for 1 cycle during MEM_READ -> mem_read = 0 at the next cycle; a re-read of the same address misses.
REQ-040 Idle quiet: read = 0 for 20 cycles after reset -> busywait = 0 and mem_read = 0 throughout.
